// File: rtl/strobe_rate_decoder_pkg.sv
// rtl/strobe_rate_decoder_pkg.sv - shared state codes, rate codes and window helper
package strobe_rate_decoder_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE    = 2'd0;
  localparam state_t S_MEASURE = 2'd1;
  localparam state_t S_LOCKED  = 2'd2;

  localparam logic [1:0] RATE_00 = 2'b00;
  localparam logic [1:0] RATE_01 = 2'b01;
  localparam logic [1:0] RATE_10 = 2'b10;
  localparam logic [1:0] RATE_11 = 2'b11;

  typedef struct packed {
    logic [63:0] lo;
    logic [63:0] hi;
  } window_t;

  // Inclusive acceptance window around a nominal period of 2^exp_v cycles.
  function automatic window_t window_bounds(input int unsigned exp_v, input int unsigned tol);
    window_t w;
    w.lo = (64'd1 << exp_v) - 64'(tol);
    w.hi = (64'd1 << exp_v) + 64'(tol);
    return w;
  endfunction

endpackage

// File: rtl/strobe_window_cmp.sv
// rtl/strobe_window_cmp.sv - classifies a measured interval into one of four rate windows
module strobe_window_cmp #(
  parameter int unsigned NB_COUNTER = 32,
  parameter int unsigned EXP0       = 22,
  parameter int unsigned EXP1       = 24,
  parameter int unsigned EXP2       = 26,
  parameter int unsigned EXP3       = 30,
  parameter int unsigned TOL        = 2
) (
  input  logic [NB_COUNTER-1:0] p_i,
  output logic                  hit_o,
  output logic [1:0]            code_o
);
  import strobe_rate_decoder_pkg::*;

  localparam window_t W0 = window_bounds(EXP0, TOL);
  localparam window_t W1 = window_bounds(EXP1, TOL);
  localparam window_t W2 = window_bounds(EXP2, TOL);
  localparam window_t W3 = window_bounds(EXP3, TOL);

  logic [63:0] p_ext;
  assign p_ext = 64'(p_i);

  always_comb begin
    hit_o  = 1'b1;
    code_o = RATE_00;
    if (p_ext >= W0.lo && p_ext <= W0.hi) begin
      code_o = RATE_00;
    end else if (p_ext >= W1.lo && p_ext <= W1.hi) begin
      code_o = RATE_01;
    end else if (p_ext >= W2.lo && p_ext <= W2.hi) begin
      code_o = RATE_10;
    end else if (p_ext >= W3.lo && p_ext <= W3.hi) begin
      code_o = RATE_11;
    end else begin
      hit_o = 1'b0;
    end
  end

endmodule

// File: rtl/strobe_rate_decoder.sv
// rtl/strobe_rate_decoder.sv - strobe interval rate decoder; STROBE_RATE_LOSS_CNT_EN enables the lock-loss counter
module strobe_rate_decoder #(
  parameter int unsigned NB_COUNTER = 32,
  parameter int unsigned EXP0       = 22,
  parameter int unsigned EXP1       = 24,
  parameter int unsigned EXP2       = 26,
  parameter int unsigned EXP3       = 30,
  parameter int unsigned TOL        = 2,
  parameter int unsigned N_CONFIRM  = 2
) (
  input  logic                  clock,
  input  logic                  i_reset,
  input  logic                  i_valid,
  output logic [1:0]            o_rate,
  output logic                  o_locked,
  output logic [NB_COUNTER-1:0] o_period,
  output logic                  o_period_valid,
  output logic                  o_err,
  output logic                  o_timeout,
  output logic [7:0]            o_loss_count
);
  import strobe_rate_decoder_pkg::*;

  localparam int unsigned           MW         = $clog2(N_CONFIRM + 1);
  localparam logic [NB_COUNTER-1:0] CNT_MAX    = NB_COUNTER'((64'd1 << EXP3) + 64'(TOL));
  localparam logic [MW-1:0]         MATCH_LOCK = MW'(N_CONFIRM);

  state_t                  state_q, state_d;
  logic [NB_COUNTER-1:0]   cnt_q, cnt_d;
  logic [1:0]              cand_q, cand_d;
  logic [MW-1:0]           match_q, match_d, match_next;
  logic [1:0]              rate_q, rate_d;
  logic                    locked_q, locked_d;
  logic [NB_COUNTER-1:0]   period_q, period_d;
  logic                    pv_q, pv_d;
  logic                    err_q, err_d;
  logic                    timeout_q, timeout_d;

  logic [NB_COUNTER-1:0]   period_meas;
  logic                    hit;
  logic [1:0]              code;
  logic                    tmo_evt;
  logic                    lock_now;

  assign period_meas = cnt_q + NB_COUNTER'(1);

  strobe_window_cmp #(
    .NB_COUNTER(NB_COUNTER), .EXP0(EXP0), .EXP1(EXP1), .EXP2(EXP2), .EXP3(EXP3), .TOL(TOL)
  ) u_cmp (
    .p_i   (period_meas),
    .hit_o (hit),
    .code_o(code)
  );

  // A strobe on the saturation edge wins over the timeout.
  assign tmo_evt    = !i_valid && (cnt_q == CNT_MAX) && (state_q != S_IDLE);
  assign match_next = (code == cand_q) ? match_q + MW'(1) : MW'(1);
  assign lock_now   = (state_q == S_MEASURE) && i_valid && hit && (match_next == MATCH_LOCK);

  always_ff @(posedge clock) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      cand_q    <= RATE_00;
      match_q   <= '0;
      rate_q    <= RATE_00;
      locked_q  <= 1'b0;
      period_q  <= '0;
      pv_q      <= 1'b0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cand_q    <= cand_d;
      match_q   <= match_d;
      rate_q    <= rate_d;
      locked_q  <= locked_d;
      period_q  <= period_d;
      pv_q      <= pv_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    match_d = match_q;
    if (i_valid)                cnt_d = '0;
    else if (cnt_q == CNT_MAX)  cnt_d = cnt_q;
    else                        cnt_d = cnt_q + NB_COUNTER'(1);
    case (state_q)
      S_IDLE: begin
        if (i_valid) state_d = S_MEASURE;
      end
      S_MEASURE: begin
        if (i_valid) begin
          if (!hit) begin
            match_d = '0;
          end else begin
            cand_d  = code;
            match_d = match_next;
            if (lock_now) state_d = S_LOCKED;
          end
        end else if (tmo_evt) begin
          state_d = S_IDLE;
          match_d = '0;
        end
      end
      S_LOCKED: begin
        if (i_valid) begin
          if (!hit) begin
            state_d = S_MEASURE;
            match_d = '0;
          end else if (code != rate_q) begin
            state_d = S_MEASURE;
            cand_d  = code;
            match_d = MW'(1);
          end
        end else if (tmo_evt) begin
          state_d = S_IDLE;
          match_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    period_d  = period_q;
    pv_d      = 1'b0;
    err_d     = 1'b0;
    locked_d  = locked_q;
    rate_d    = rate_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (i_valid) timeout_d = 1'b0;
      end
      S_MEASURE, S_LOCKED: begin
        if (i_valid) begin
          period_d = period_meas;
          pv_d     = 1'b1;
          err_d    = !hit;
          if (lock_now) begin
            locked_d = 1'b1;
            rate_d   = code;
          end else if (state_q == S_LOCKED && (!hit || code != rate_q)) begin
            locked_d = 1'b0;
          end
        end else if (tmo_evt) begin
          timeout_d = 1'b1;
          locked_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign o_rate         = rate_q;
  assign o_locked       = locked_q;
  assign o_period       = period_q;
  assign o_period_valid = pv_q;
  assign o_err          = err_q;
  assign o_timeout      = timeout_q;

`ifdef STROBE_RATE_LOSS_CNT_EN
  logic [7:0] loss_q, loss_d;

  always_comb begin
    loss_d = loss_q;
    if (state_q == S_LOCKED && state_d != S_LOCKED && loss_q != 8'hFF) loss_d = loss_q + 8'd1;
  end

  always_ff @(posedge clock) begin
    if (i_reset) loss_q <= 8'd0;
    else         loss_q <= loss_d;
  end

  assign o_loss_count = loss_q;
`else
  assign o_loss_count = 8'd0;
`endif

endmodule
